// File: rtl/amm_arbiter_if.sv
// avalon_mm_if: Avalon-MM bus bundle (32-bit address, 16-bit data) shared by the arbiter and its peers.
interface avalon_mm_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output read, write, address, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/amm_arbiter.sv
// amm_arbiter: N-to-1 Avalon-MM arbiter, one transfer per grant, in-order read response routing.
// Define AMM_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-first priority.
module amm_arbiter #(
  parameter int unsigned MST_CNT     = 2,
  parameter int unsigned MAX_PENDING = 4
) (
  input logic         clk_i,
  input logic         rst_n_i,
  avalon_mm_if.slave  mst_mem_if [MST_CNT],
  avalon_mm_if.master slv_mem_if
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = $clog2(MST_CNT);
  localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);
  localparam int unsigned PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  typedef enum logic {ARB, XFER} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   fifo_q [MAX_PENDING];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MST_CNT-1:0] mst_rd, mst_wr, mst_req, eligible;
  logic [MST_CNT-1:0] mst_wait_c, mst_rdv_c;
  logic [ADDR_W-1:0]  mst_addr  [MST_CNT];
  logic [DATA_W-1:0]  mst_wdata [MST_CNT];

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_sel;
  int unsigned        rr_idx;
  logic               in_xfer, owner_req, fifo_full, push, pop;
  logic [IDX_W-1:0]   fifo_head;

  // Flatten the master interface array so it can be indexed by owner.
  for (genvar g = 0; g < MST_CNT; g++) begin : g_mst
    assign mst_rd[g]    = mst_mem_if[g].read;
    assign mst_wr[g]    = mst_mem_if[g].write;
    assign mst_addr[g]  = mst_mem_if[g].address;
    assign mst_wdata[g] = mst_mem_if[g].writedata;
    assign mst_mem_if[g].waitrequest   = mst_wait_c[g];
    assign mst_mem_if[g].readdatavalid = mst_rdv_c[g];
    assign mst_mem_if[g].readdata      = slv_mem_if.readdata;
    assign mst_wait_c[g] = !(in_xfer && (owner_q == IDX_W'(g))) || slv_mem_if.waitrequest;
    assign mst_rdv_c[g]  = pop && (fifo_head == IDX_W'(g));
  end

  assign mst_req   = mst_rd | mst_wr;
  assign fifo_full = (count_q == CNT_W'(MAX_PENDING));
  assign eligible  = mst_req & ~(mst_rd & {MST_CNT{fifo_full}});
  assign in_xfer   = (state_q == XFER);
  assign owner_req = mst_req[owner_q];
  assign fifo_head = fifo_q[rd_ptr_q];
  assign pop       = slv_mem_if.readdatavalid && (count_q != '0);

  assign slv_mem_if.read      = in_xfer && mst_rd[owner_q];
  assign slv_mem_if.write     = in_xfer && mst_wr[owner_q];
  assign slv_mem_if.address   = mst_addr[owner_q];
  assign slv_mem_if.writedata = mst_wdata[owner_q];

  // Grant selection among eligible masters.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    rr_sel      = '0;
`ifdef AMM_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < MST_CNT; i++) begin
      if (!grant_found && eligible[IDX_W'(i)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
`else
    for (int unsigned k = 1; k <= MST_CNT; k++) begin
      rr_idx = 32'(last_grant_q) + k;
      if (rr_idx >= MST_CNT) rr_idx = rr_idx - MST_CNT;
      rr_sel = IDX_W'(rr_idx);
      if (!grant_found && eligible[rr_sel]) begin
        grant_found = 1'b1;
        grant_idx   = rr_sel;
      end
    end
`endif
  end

  // Next-state logic: ARB latches a winner, XFER waits for acceptance.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    push         = 1'b0;
    case (state_q)
      ARB: begin
        if (grant_found) begin
          owner_d = grant_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!owner_req) begin
          state_d = ARB;
        end else if (!slv_mem_if.waitrequest) begin
          state_d      = ARB;
          last_grant_d = owner_q;
          push         = mst_rd[owner_q];
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == MAX_PENDING - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ARB;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(MST_CNT - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= owner_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule
